// File: rtl/wb_dma_copy.sv
// Wishbone B3 classic single-transfer block copier: read a word, write it, repeat.
// One word costs a read phase and a write phase; cyc/stb stay up across the whole job.
module wb_dma_copy #(
    parameter int dw = 32,
    parameter int aw = 32,
    parameter int lw = 16
) (
    input  logic          wb_clk_i,
    input  logic          wb_rst_n_i,
    input  logic          start_i,
    input  logic [aw-1:0] src_adr_i,
    input  logic [aw-1:0] dst_adr_i,
    input  logic [lw-1:0] len_i,
    output logic          busy_o,
    output logic          done_o,
    output logic          err_o,
    output logic [lw-1:0] count_o,
    output logic [aw-1:0] wbm_adr_o,
    output logic [dw-1:0] wbm_dat_o,
    output logic [3:0]    wbm_sel_o,
    output logic          wbm_we_o,
    output logic          wbm_cyc_o,
    output logic          wbm_stb_o,
    output logic [2:0]    wbm_cti_o,
    output logic [1:0]    wbm_bte_o,
    input  logic [dw-1:0] wbm_dat_i,
    input  logic          wbm_ack_i,
    input  logic          wbm_err_i,
    input  logic          wbm_rty_i
);
    typedef enum logic [1:0] {IDLE, RD, WR, FIN} state_t;

    state_t        state_reg;
    logic [aw-1:0] src_reg;
    logic [aw-1:0] dst_reg;
    logic [lw-1:0] len_reg;

    logic          bus_fault;
    logic [lw:0]   count_inc;
    logic          more_words;
    logic [aw-1:0] src_next_adr;
    logic [aw-1:0] dst_cur_adr;

    assign wbm_cti_o = 3'b000;
    assign wbm_bte_o = 2'b00;

    // Retry is handled exactly like an error: the job is abandoned.
    assign bus_fault    = wbm_err_i | wbm_rty_i;
    assign count_inc    = {1'b0, count_o} + {{lw{1'b0}}, 1'b1};
    assign more_words   = count_inc < {1'b0, len_reg};
    assign src_next_adr = src_reg + (aw'(count_inc) << 2);
    assign dst_cur_adr  = dst_reg + (aw'(count_o) << 2);

    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
            state_reg <= IDLE;
            src_reg   <= '0;
            dst_reg   <= '0;
            len_reg   <= '0;
            count_o   <= '0;
            busy_o    <= 1'b0;
            done_o    <= 1'b0;
            err_o     <= 1'b0;
            wbm_adr_o <= '0;
            wbm_dat_o <= '0;
            wbm_sel_o <= '0;
            wbm_we_o  <= 1'b0;
            wbm_cyc_o <= 1'b0;
            wbm_stb_o <= 1'b0;
        end else begin
            done_o <= 1'b0;
            err_o  <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (start_i) begin
                        src_reg <= {src_adr_i[aw-1:2], 2'b00};
                        dst_reg <= {dst_adr_i[aw-1:2], 2'b00};
                        len_reg <= len_i;
                        count_o <= '0;
                        busy_o  <= 1'b1;
                        if (len_i != '0) begin
                            state_reg <= RD;
                            wbm_adr_o <= {src_adr_i[aw-1:2], 2'b00};
                            wbm_we_o  <= 1'b0;
                            wbm_sel_o <= 4'b1111;
                            wbm_cyc_o <= 1'b1;
                            wbm_stb_o <= 1'b1;
                        end else begin
                            state_reg <= FIN;
                        end
                    end
                end
                RD, WR: begin
                    // Fault beats a simultaneous ack, so that word is never counted.
                    if (wbm_stb_o && bus_fault) begin
                        state_reg <= IDLE;
                        wbm_cyc_o <= 1'b0;
                        wbm_stb_o <= 1'b0;
                        wbm_we_o  <= 1'b0;
                        wbm_sel_o <= '0;
                        busy_o    <= 1'b0;
                        err_o     <= 1'b1;
                    end else if (wbm_stb_o && wbm_ack_i) begin
                        if (state_reg == RD) begin
                            state_reg <= WR;
                            wbm_we_o  <= 1'b1;
                            wbm_adr_o <= dst_cur_adr;
                            wbm_dat_o <= wbm_dat_i;
                        end else begin
                            count_o <= count_inc[lw-1:0];
                            if (more_words) begin
                                state_reg <= RD;
                                wbm_we_o  <= 1'b0;
                                wbm_adr_o <= src_next_adr;
                            end else begin
                                state_reg <= FIN;
                                wbm_we_o  <= 1'b0;
                                wbm_cyc_o <= 1'b0;
                                wbm_stb_o <= 1'b0;
                                wbm_sel_o <= '0;
                            end
                        end
                    end
                end
                FIN: begin
                    done_o    <= 1'b1;
                    busy_o    <= 1'b0;
                    state_reg <= IDLE;
                end
                default: state_reg <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_wb_dma_copy.sv
// Scoreboard bench for wb_dma_copy: stimulus queues expected bus phases and
// completion events, a negedge monitor pops and compares them as the DUT produces them.
module tb_wb_dma_copy;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [31:0] src = '0;
    logic [31:0] dst = '0;
    logic [15:0] len = '0;
    logic        busy, done, err;
    logic [15:0] count;
    logic [31:0] adr, dat_o;
    logic [3:0]  sel;
    logic        we, cyc, stb;
    logic [2:0]  cti;
    logic [1:0]  bte;
    logic [31:0] sdat = '0;
    logic        ack = 1'b0;
    logic        serr = 1'b0;
    logic        rty = 1'b0;

    logic [31:0] mem [0:255];
    int          rd_total = 0;
    int          err_at = -1;

    int checks = 0;
    int failures = 0;

    typedef struct {
        int          kind;   // 0 read, 1 write, 2 done, 3 err
        logic [31:0] adr;    // bus address, or count_o for done/err
        logic [31:0] dat;
    } ev_t;
    ev_t sb[$];

    always #5 clk = ~clk;

    wb_dma_copy dut (
        .wb_clk_i(clk), .wb_rst_n_i(rst_n), .start_i(start),
        .src_adr_i(src), .dst_adr_i(dst), .len_i(len),
        .busy_o(busy), .done_o(done), .err_o(err), .count_o(count),
        .wbm_adr_o(adr), .wbm_dat_o(dat_o), .wbm_sel_o(sel), .wbm_we_o(we),
        .wbm_cyc_o(cyc), .wbm_stb_o(stb), .wbm_cti_o(cti), .wbm_bte_o(bte),
        .wbm_dat_i(sdat), .wbm_ack_i(ack), .wbm_err_i(serr), .wbm_rty_i(rty)
    );

    // Slave: responds one cycle after a request, never on two cycles in a row.
    always @(posedge clk) begin
        if (!rst_n) begin
            ack  <= 1'b0;
            serr <= 1'b0;
            for (int i = 0; i < 256; i++)
                mem[i] <= (i < 8) ? 32'(32'h11111111 * (i + 1)) :
                          (i == 255) ? 32'hDEADBEEF : 32'h0;
        end else if (cyc && stb && !ack && !serr) begin
            if (!we && (rd_total + 1 == err_at)) begin
                serr     <= 1'b1;
                rd_total <= rd_total + 1;
            end else begin
                ack <= 1'b1;
                if (we) mem[adr[9:2]] <= dat_o;
                else begin
                    sdat     <= mem[adr[9:2]];
                    rd_total <= rd_total + 1;
                end
            end
        end else begin
            ack  <= 1'b0;
            serr <= 1'b0;
        end
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h expected=%h", name, got, exp);
        end
    endtask

    task automatic push(input int k, input logic [31:0] a, input logic [31:0] d);
        ev_t e;
        e.kind = k; e.adr = a; e.dat = d;
        sb.push_back(e);
    endtask

    task automatic observe(input int k, input logic [31:0] a, input logic [31:0] d);
        ev_t e;
        $display("txn kind=%0d adr=%h dat=%h count=%0d", k, a, d, count);
        if (sb.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL sb_unexpected got kind=%0d adr=%h expected no event", k, a);
        end else begin
            e = sb.pop_front();
            check("sb_kind", 32'(k), 32'(e.kind));
            check("sb_adr", a, e.adr);
            check("sb_dat", d, e.dat);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (cyc && stb && ack) begin
                if (we) check("wr_sel", {28'h0, sel}, 32'hF);
                observe(we ? 1 : 0, adr, we ? dat_o : sdat);
            end
            if (done) observe(2, {16'h0, count}, 32'h0);
            if (err)  observe(3, {16'h0, count}, 32'h0);
        end
    end

    task automatic start_job(input logic [31:0] s, input logic [31:0] d, input logic [15:0] l);
        @(posedge clk);
        #1 src = s; dst = d; len = l; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic wait_end(output int n, output int hi, output bit sd, output bit se);
        n = 0; hi = 0; sd = 1'b0; se = 1'b0;
        while (!sd && !se && n < 500) begin
            @(negedge clk);
            n++;
            if (cyc) hi++;
            if (done) sd = 1'b1;
            if (err) begin
                se = 1'b1;
                check("cyc_at_err", {31'h0, cyc}, 32'h0);
            end
        end
        if (!sd && !se) begin
            checks++;
            failures++;
            $display("FAIL job_timeout got no done/err expected completion within 500 cycles");
        end
    endtask

    task automatic finish_job(input string name, input int exp_n, input int exp_hi, input bit exp_done);
        int n, hi;
        bit sd, se;
        wait_end(n, hi, sd, se);
        check({name, "_cycles"}, 32'(n), 32'(exp_n));
        check({name, "_cyc_hi"}, 32'(hi), 32'(exp_hi));
        check({name, "_done"}, {31'h0, sd}, {31'h0, exp_done});
        check({name, "_busy"}, {31'h0, busy}, 32'h0);
        @(negedge clk);
        check({name, "_pulse"}, {30'h0, done, err}, 32'h0);
        check({name, "_sb_empty"}, 32'(sb.size()), 32'h0);
    endtask

    initial begin
        int guard;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", {31'h0, busy}, 32'h0);
        check("rst_done_err", {30'h0, done, err}, 32'h0);
        check("rst_count", {16'h0, count}, 32'h0);
        check("rst_bus", {29'h0, cyc, stb, we}, 32'h0);
        check("rst_adr", adr, 32'h0);
        check("rst_dat", dat_o, 32'h0);
        rst_n = 1'b1;

        // Directed copy of four words.
        for (int i = 0; i < 4; i++) begin
            push(0, 32'(i * 4), 32'(32'h11111111 * (i + 1)));
            push(1, 32'(32'h100 + i * 4), 32'(32'h11111111 * (i + 1)));
        end
        push(2, 32'd4, 32'h0);
        start_job(32'h000, 32'h100, 16'd4);
        finish_job("copy4", 18, 16, 1'b1);
        for (int i = 0; i < 4; i++)
            check("copy4_mem", mem[8'h40 + i], 32'(32'h11111111 * (i + 1)));

        // Three words from a different region: 6 phases, 4 cycles per word.
        for (int i = 0; i < 3; i++) begin
            push(0, 32'(32'h010 + i * 4), 32'(32'h11111111 * (i + 5)));
            push(1, 32'(32'h140 + i * 4), 32'(32'h11111111 * (i + 5)));
        end
        push(2, 32'd3, 32'h0);
        start_job(32'h010, 32'h140, 16'd3);
        finish_job("gap3", 14, 12, 1'b1);

        // Error on the third read of a five-word job.
        err_at = rd_total + 3;
        push(0, 32'h000, 32'h11111111); push(1, 32'h1C0, 32'h11111111);
        push(0, 32'h004, 32'h22222222); push(1, 32'h1C4, 32'h22222222);
        push(3, 32'd2, 32'h0);
        start_job(32'h000, 32'h1C0, 16'd5);
        finish_job("err5", 11, 10, 1'b0);
        err_at = -1;

        // Zero length: done two cycles after start, no bus cycle.
        push(2, 32'd0, 32'h0);
        start_job(32'h000, 32'h100, 16'd0);
        finish_job("len0", 2, 0, 1'b0 == 1'b0);

        // A second start during a busy job must be ignored.
        for (int i = 0; i < 4; i++) begin
            push(0, 32'(i * 4), 32'(32'h11111111 * (i + 1)));
            push(1, 32'(32'h200 + i * 4), 32'(32'h11111111 * (i + 1)));
        end
        push(2, 32'd4, 32'h0);
        start_job(32'h000, 32'h200, 16'd4);
        fork
            begin
                repeat (4) @(posedge clk);
                #1 src = 32'h040; dst = 32'h300; len = 16'd2; start = 1'b1;
                @(posedge clk);
                #1 start = 1'b0;
            end
        join_none
        finish_job("busy_start", 18, 16, 1'b1);

        // Unaligned source at the top of the address space wraps to zero.
        push(0, 32'hFFFF_FFFC, 32'hDEADBEEF); push(1, 32'h180, 32'hDEADBEEF);
        push(0, 32'h0000_0000, 32'h11111111); push(1, 32'h184, 32'h11111111);
        push(2, 32'd2, 32'h0);
        start_job(32'hFFFF_FFFF, 32'h182, 16'd2);
        finish_job("wrap", 10, 8, 1'b1);

        // Reset during the second write phase.
        push(0, 32'h000, 32'h11111111); push(1, 32'h080, 32'h11111111);
        push(0, 32'h004, 32'h22222222);
        start_job(32'h000, 32'h080, 16'd4);
        guard = 0;
        while (!(we && count == 16'd1) && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        check("rstmid_reach_wr", {31'h0, we && count == 16'd1}, 32'h1);
        rst_n = 1'b0;
        #1;
        check("rstmid_bus", {29'h0, cyc, stb, we}, 32'h0);
        check("rstmid_count", {16'h0, count}, 32'h0);
        check("rstmid_busy_adr", {31'h0, busy} | adr, 32'h0);
        check("rstmid_sb_empty", 32'(sb.size()), 32'h0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        push(0, 32'h008, 32'h33333333); push(1, 32'h090, 32'h33333333);
        push(0, 32'h00C, 32'h44444444); push(1, 32'h094, 32'h44444444);
        push(2, 32'd2, 32'h0);
        start_job(32'h008, 32'h090, 16'd2);
        finish_job("after_rst", 10, 8, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
